// File: rtl/adder_int_pipe.sv
// adder_int_pipe
//   Pipelined integer add/sub/compare unit for the RV32I execution stage.
//   Computes ADD, SUB, ADDI (sign-extended immediate), SLT and SLTU.
//   The carry chain is cut into STAGES slices of SW = DATA_WIDTH/STAGES bits.
//   Each slice sits behind its own register stage. The destination tag
//   travels with the op.
//
// Optional feature macro: ADDER_FLAGS_EN
//   Adds the out_flags port {zero, neg, carry, ovf}, pipelined with the op.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   flush      in   synchronous kill of every in-flight op
//   in_valid   in   op presented
//   in_ready   out  op accepted this cycle (never depends on in_valid)
//   op         in   0 ADD, 1 SUB, 2 ADDI, 3 SLT, 4 SLTU, 5-7 reserved
//   src1       in   operand A
//   src2       in   operand B (ignored for ADDI)
//   imm        in   immediate for ADDI
//   tag_in     in   destination tag
//   out_valid  out  result valid
//   out_ready  in   consumer takes result
//   out_data   out  result
//   out_tag    out  tag of result
//   out_flags  out  {zero, neg, carry, ovf} (ADDER_FLAGS_EN only)
module adder_int_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 12,
  parameter int STAGES     = 2,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic [IMM_WIDTH-1:0]  imm,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag
`ifdef ADDER_FLAGS_EN
  ,
  output logic [3:0]            out_flags
`endif
);

  localparam int SW   = DATA_WIDTH / STAGES;
  localparam int LAST = STAGES - 1;
  localparam int NR   = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int MSB  = DATA_WIDTH - 1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_SLT  = 3'd3;
  localparam logic [2:0] OP_SLTU = 3'd4;

  localparam logic [DATA_WIDTH-1:0] SLICE_MASK = DATA_WIDTH'({SW{1'b1}});

  // Signed-overflow rule for A + B' where B' is the (possibly inverted) operand.
  function automatic logic ovf_of(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Map the raw wrap-around sum onto the architectural result of each op.
  function automatic logic [DATA_WIDTH-1:0] result_data(
    input logic [2:0]            f_op,
    input logic [DATA_WIDTH-1:0] sum,
    input logic                  cy,
    input logic                  a_msb,
    input logic                  b_msb
  );
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    case (f_op)
      OP_ADD, OP_SUB, OP_ADDI: r = sum;
      OP_SLT:  r[0] = sum[MSB] ^ ovf_of(a_msb, b_msb, sum[MSB]);
      OP_SLTU: r[0] = ~cy;
      default: r = '0;
    endcase
    return r;
  endfunction

`ifdef ADDER_FLAGS_EN
  function automatic logic [3:0] result_flags(
    input logic [2:0]            f_op,
    input logic [DATA_WIDTH-1:0] data,
    input logic [DATA_WIDTH-1:0] sum,
    input logic                  cy,
    input logic                  a_msb,
    input logic                  b_msb
  );
    logic [3:0] f;
    if (f_op > OP_SLTU) f = 4'b0000;
    else f = {(data == '0), data[MSB], cy, ovf_of(a_msb, b_msb, sum[MSB])};
    return f;
  endfunction
`endif

  logic signed [DATA_WIDTH-1:0] imm_sext;
  logic [DATA_WIDTH-1:0]        b_sel;
  logic                         sub_op;

  // Per-stage combinational inputs/outputs (stage 0 fed from the ports)
  logic [DATA_WIDTH-1:0] a_s   [STAGES];
  logic [DATA_WIDTH-1:0] b_s   [STAGES];
  logic [DATA_WIDTH-1:0] sum_s [STAGES];
  logic [DATA_WIDTH-1:0] sum_o [STAGES];
  logic [2:0]            op_s  [STAGES];
  logic [TAG_WIDTH-1:0]  tag_s [STAGES];
  logic                  cin_s  [STAGES];
  logic                  cout_s [STAGES];
  logic                  vin_s  [STAGES];
  logic                  rdy    [STAGES];

  // Inter-stage registers (stage k feeds stage k+1)
  logic [DATA_WIDTH-1:0] a_p   [NR];
  logic [DATA_WIDTH-1:0] b_p   [NR];
  logic [DATA_WIDTH-1:0] sum_p [NR];
  logic [2:0]            op_p  [NR];
  logic [TAG_WIDTH-1:0]  tag_p [NR];
  logic                  cy_p  [NR];
  logic                  vld_p [NR];

  assign imm_sext = DATA_WIDTH'(signed'(imm));
  assign sub_op   = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
  assign b_sel    = (op == OP_ADDI) ? imm_sext : (sub_op ? ~src2 : src2);

  // Ripple backpressure: a stage may load when empty or when the next one moves.
  always_comb begin
    rdy[LAST] = ~out_valid | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) rdy[k] = ~vld_p[k] | rdy[k+1];
  end

  assign in_ready = rdy[0] & ~flush;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW:0] slice;

    if (k == 0) begin : g_src
      assign a_s[k]   = src1;
      assign b_s[k]   = b_sel;
      assign sum_s[k] = '0;
      assign cin_s[k] = sub_op;
      assign op_s[k]  = op;
      assign tag_s[k] = tag_in;
      assign vin_s[k] = in_valid & in_ready;
    end else begin : g_reg
      assign a_s[k]   = a_p[k-1];
      assign b_s[k]   = b_p[k-1];
      assign sum_s[k] = sum_p[k-1];
      assign cin_s[k] = cy_p[k-1];
      assign op_s[k]  = op_p[k-1];
      assign tag_s[k] = tag_p[k-1];
      assign vin_s[k] = vld_p[k-1];
    end

    assign slice = {1'b0, a_s[k][k*SW +: SW]} + {1'b0, b_s[k][k*SW +: SW]}
                 + {{SW{1'b0}}, cin_s[k]};
    // Keep the lower slices already computed, drop in this stage's slice.
    assign sum_o[k]  = (sum_s[k] & ~(SLICE_MASK << (k*SW)))
                     | (DATA_WIDTH'(slice[SW-1:0]) << (k*SW));
    assign cout_s[k] = slice[SW];
  end

  // ---- inter-stage boundaries: control ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NR; k++) vld_p[k] <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES - 1; k++) begin
        if (flush)       vld_p[k] <= 1'b0;
        else if (rdy[k]) vld_p[k] <= vin_s[k];
      end
    end
  end

  // ---- inter-stage boundaries: data ----
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES - 1; k++) begin
      if (rdy[k] && vin_s[k]) begin
        a_p[k]   <= a_s[k];
        b_p[k]   <= b_s[k];
        sum_p[k] <= sum_o[k];
        cy_p[k]  <= cout_s[k];
        op_p[k]  <= op_s[k];
        tag_p[k] <= tag_s[k];
      end
    end
  end

  // ---- final stage boundary: formatted result ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
`ifdef ADDER_FLAGS_EN
      out_flags <= 4'b0000;
`endif
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (rdy[LAST]) out_valid <= vin_s[LAST];
      if (rdy[LAST] && vin_s[LAST]) begin
        out_data <= result_data(op_s[LAST], sum_o[LAST], cout_s[LAST],
                                a_s[LAST][MSB], b_s[LAST][MSB]);
        out_tag  <= tag_s[LAST];
`ifdef ADDER_FLAGS_EN
        out_flags <= result_flags(op_s[LAST],
                                  result_data(op_s[LAST], sum_o[LAST], cout_s[LAST],
                                              a_s[LAST][MSB], b_s[LAST][MSB]),
                                  sum_o[LAST], cout_s[LAST],
                                  a_s[LAST][MSB], b_s[LAST][MSB]);
`endif
      end
    end
  end

endmodule
